// File: rtl/bsg_print_stat_snoop_pkg.sv
// bsg_print_stat_snoop_pkg: capture-entry type macro, default print-stat EPA and link-id width helper
`ifndef BSG_PRINT_STAT_SNOOP_PKG_SV
`define BSG_PRINT_STAT_SNOOP_PKG_SV
`define BSG_PRINT_STAT_ENTRY_DECLARE(data_width_mp, link_width_mp, ts_width_mp) \
  typedef struct packed { \
    logic [data_width_mp-1:0] tag; \
    logic [link_width_mp-1:0] link; \
    logic [ts_width_mp-1:0] ts; \
  } bsg_print_stat_entry_s
package bsg_print_stat_snoop_pkg;
  localparam logic [27:0] print_stat_epa_gp = 28'h0000_D0C;
  function automatic int link_width(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage
`endif

// File: rtl/bsg_arb_round_robin.sv
// bsg_arb_round_robin: one-hot grant to the lowest requester at or after the pointer; pointer moves past each grant
module bsg_arb_round_robin #(
  parameter int width_p = 4,
  localparam int lg_p = (width_p > 1) ? $clog2(width_p) : 1
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               en_i,
  input  logic [width_p-1:0] reqs_i,
  output logic               v_o,
  output logic [lg_p-1:0]    tag_o,
  output logic [width_p-1:0] grants_o
);
  logic [lg_p-1:0] ptr_r, idx, sel;
  logic found;
  always_comb begin
    found = 1'b0;
    sel = '0;
    idx = '0;
    for (int k = 0; k < width_p; k++) begin
      idx = lg_p'((int'(ptr_r) + k) % width_p);
      if (!found && reqs_i[idx]) begin
        found = 1'b1;
        sel = idx;
      end
    end
  end
  assign v_o = en_i & found;
  assign tag_o = sel;
  assign grants_o = v_o ? width_p'(1) << sel : '0;
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) ptr_r <= '0;
    else if (v_o) ptr_r <= (int'(sel) == width_p - 1) ? '0 : sel + 1'b1;
endmodule

// File: rtl/bsg_fifo_1r1w_small.sv
// bsg_fifo_1r1w_small: first-word-fall-through FIFO; writes accepted when not full or when the head is consumed
module bsg_fifo_1r1w_small #(
  parameter int width_p = 8,
  parameter int els_p = 8,
  localparam int ptr_w = $clog2(els_p),
  localparam int cnt_w = $clog2(els_p + 1)
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  input  logic               yumi_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  output logic               full_o,
  output logic [cnt_w-1:0]   count_o
);
  logic [width_p-1:0] mem_r [els_p];
  logic [ptr_w-1:0] rptr_r, wptr_r;
  logic [cnt_w-1:0] count_r;
  logic we;
  assign full_o = count_r == cnt_w'(els_p);
  assign v_o = count_r != '0;
  assign we = v_i & (~full_o | yumi_i);
  assign data_o = v_o ? mem_r[rptr_r] : '0;
  assign count_o = count_r;
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) begin
      rptr_r <= '0;
      wptr_r <= '0;
      count_r <= '0;
    end else begin
      if (we) wptr_r <= wptr_r + 1'b1;
      if (yumi_i) rptr_r <= rptr_r + 1'b1;
      count_r <= count_r + cnt_w'(we) - cnt_w'(yumi_i);
    end
  always_ff @(posedge clk_i)
    if (we) mem_r[wptr_r] <= data_i;
endmodule

// File: rtl/bsg_print_stat_snoop_multi.sv
// bsg_print_stat_snoop_multi: snoops N request links for print-stat stores, buffers {tag,link,ts} entries, counts drops
module bsg_print_stat_snoop_multi
  import bsg_print_stat_snoop_pkg::*;
#(
  parameter int num_links_p = 4,
  parameter int addr_width_p = 28,
  parameter int data_width_p = 32,
  parameter int ts_width_p = 64,
  parameter int fifo_els_p = 8,
  parameter logic [addr_width_p-1:0] stat_epa_p = addr_width_p'(print_stat_epa_gp),
  parameter int drop_ctr_width_p = 16,
  localparam int link_width_lp = link_width(num_links_p),
  localparam int pending_width_lp = $clog2(fifo_els_p + 1)
) (
  input  logic                                clk_i,
  input  logic                                reset_n_i,
  input  logic                                en_i,
  input  logic [ts_width_p-1:0]               ctr_i,
  input  logic [num_links_p-1:0]              pkt_v_i,
  input  logic [num_links_p-1:0]              pkt_ready_i,
  input  logic [num_links_p-1:0]              pkt_store_i,
  input  logic [num_links_p*addr_width_p-1:0] pkt_addr_i,
  input  logic [num_links_p*data_width_p-1:0] pkt_data_i,
  output logic                                stat_v_o,
  output logic [data_width_p-1:0]             stat_tag_o,
  output logic [link_width_lp-1:0]            stat_link_o,
  output logic [ts_width_p-1:0]               stat_ts_o,
  input  logic                                stat_yumi_i,
  output logic [drop_ctr_width_p-1:0]         drop_count_o,
  output logic [pending_width_lp-1:0]         pending_o
);
  `BSG_PRINT_STAT_ENTRY_DECLARE(data_width_p, link_width_lp, ts_width_p);
  localparam int sum_w = drop_ctr_width_p + 5;
  bsg_print_stat_entry_s [num_links_p-1:0] cap_r;
  bsg_print_stat_entry_s head;
  logic [num_links_p-1:0] cap_v_r, hit, load, drop, grants;
  logic [link_width_lp-1:0] grant_tag;
  logic grant_v, fifo_full;
  logic [drop_ctr_width_p-1:0] drop_r;
  logic [sum_w-1:0] drop_sum;
  for (genvar i = 0; i < num_links_p; i++) begin : g_hit
    assign hit[i] = en_i & pkt_v_i[i] & pkt_ready_i[i] & pkt_store_i[i]
                  & (pkt_addr_i[i*addr_width_p +: addr_width_p] == stat_epa_p);
  end
  assign load = hit & (~cap_v_r | grants);
  assign drop = hit & cap_v_r & ~grants;
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) cap_v_r <= '0;
    else cap_v_r <= load | (cap_v_r & ~grants);
  always_ff @(posedge clk_i)
    for (int j = 0; j < num_links_p; j++)
      if (load[j]) cap_r[j] <= '{tag: pkt_data_i[j*data_width_p +: data_width_p], link: link_width_lp'(j), ts: ctr_i};
  always_comb begin
    drop_sum = sum_w'(drop_r);
    for (int j = 0; j < num_links_p; j++) drop_sum = drop_sum + sum_w'(drop[j]);
  end
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) drop_r <= '0;
    else drop_r <= |drop_sum[sum_w-1:drop_ctr_width_p] ? '1 : drop_sum[drop_ctr_width_p-1:0];
  bsg_arb_round_robin #(.width_p(num_links_p)) arb (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .en_i(~fifo_full | stat_yumi_i),
    .reqs_i(cap_v_r), .v_o(grant_v), .tag_o(grant_tag), .grants_o(grants)
  );
  bsg_fifo_1r1w_small #(.width_p($bits(bsg_print_stat_entry_s)), .els_p(fifo_els_p)) fifo (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .v_i(grant_v), .data_i(cap_r[grant_tag]),
    .yumi_i(stat_yumi_i), .v_o(stat_v_o), .data_o(head), .full_o(fifo_full), .count_o(pending_o)
  );
  assign stat_tag_o = head.tag;
  assign stat_link_o = head.link;
  assign stat_ts_o = head.ts;
  assign drop_count_o = drop_r;
`ifndef SYNTHESIS
  always @(posedge clk_i)
    if (reset_n_i) assert (!(stat_yumi_i && !stat_v_o)) else $error("stat_yumi_i asserted while stat_v_o is low");
`endif
endmodule

// File: doc/bsg_print_stat_snoop_multi.md
Name: bsg_print_stat_snoop_multi

Overview:
Multi-link successor to the single-link print-stat snooper. Watches N manycore-side request links for store packets to the print-stat EPA. Each hit is captured as an entry of {tag, link id, timestamp} and buffered for DPI/host readout through a valid/yumi FIFO interface. Lost events are counted. Sits in the testbench top beside the global cycle counter, one snoop port per host/IO link.

Parameters:
num_links_p, 4, number of snooped links (1..16)
addr_width_p, 28, EPA width of a snooped packet
data_width_p, 32, packet data width; the tag is the full data word
ts_width_p, 64, timestamp width, matches the global counter
fifo_els_p, 8, output FIFO depth (power of 2, >=2)
stat_epa_p, 'h0000_D0C, EPA that identifies a print-stat store
drop_ctr_width_p, 16, drop counter width

Ports:
clk_i  in  1  clock
reset_n_i  in  1  async active-low reset
en_i  in  1  snoop enable; hits are ignored when 0
ctr_i  in  ts_width_p  global cycle counter value
pkt_v_i  in  num_links_p  per-link packet valid
pkt_ready_i  in  num_links_p  per-link sink ready; a transfer is v&ready
pkt_store_i  in  num_links_p  per-link opcode-is-store
pkt_addr_i  in  num_links_p*addr_width_p  per-link EPA, link 0 in the LSBs
pkt_data_i  in  num_links_p*data_width_p  per-link data
stat_v_o  out  1  FIFO head valid
stat_tag_o  out  data_width_p  head tag
stat_link_o  out  clog2(num_links_p) (min 1)  head link id
stat_ts_o  out  ts_width_p  head timestamp
stat_yumi_i  in  1  consume head; only legal when stat_v_o=1
drop_count_o  out  drop_ctr_width_p  saturating count of lost events
pending_o  out  clog2(fifo_els_p+1)  FIFO occupancy

Behaviour:
- Reset is asynchronous and active-low. While reset_n_i=0: all outputs are 0, capture registers are empty, the FIFO is empty, the round-robin pointer is 0, and drop_count_o is 0.
- Hit on link i in cycle t: en_i & pkt_v_i[i] & pkt_ready_i[i] & pkt_store_i[i] & (addr_i == stat_epa_p).
- On a hit, capture register i loads {data, i, ctr_i sampled in cycle t} at the edge ending t.
- Arbitration:
  - One capture register is granted per cycle, round-robin: the lowest index at or after the pointer wins.
  - A grant requires the FIFO not to be full.
  - After a grant, the pointer moves to the granted index + 1, wrapping modulo num_links_p.
- The granted entry is written to the FIFO in the same cycle and the capture register is cleared.
- Uncontested latency: hit at t, capture valid at t+1, FIFO write at the end of t+1, stat_v_o=1 at t+2.
- The FIFO is first-word-fall-through; the head fields are stable while stat_v_o=1 and stat_yumi_i=0.
- Hit while capture register i is already full:
  - If register i is granted in that same cycle, the new hit is accepted and loads the register.
  - Otherwise the new hit is dropped and drop_count_o increments.
- Multiple drops in one cycle add their popcount to drop_count_o. The counter saturates at all-ones and never wraps.
- FIFO full: no grant. Capture registers hold their entries.
- Simultaneous yumi and grant while the FIFO is full: the grant proceeds. Write is allowed when the FIFO is not full or yumi=1.
- en_i deasserted: entries already captured still drain; only new hits are suppressed.
- stat_yumi_i with stat_v_o=0 is illegal and is caught by an assertion (nonsynth, `ifndef SYNTHESIS`).
- pending_o is the registered occupancy: +1 on write, -1 on yumi, unchanged when both happen.

Decomposition:
- Package bsg_print_stat_snoop_pkg:
  - typedef bsg_print_stat_entry_s {tag, link, ts}, parametrised via a declare macro.
  - Default print-stat EPA constant.
- Sub-modules: the existing round-robin arbiter (bsg_arb_round_robin) and a 1r1w small FIFO. The only new logic is the capture register array and the drop counter.

Test Plan:
1. Reset: hold reset_n_i=0 with hits driven, then release. All outputs are 0 throughout reset, and nothing is captured.
2. Single hit on link 2, tag 'hCAFE, ctr_i=100. At t+2: stat_v_o=1, tag 'hCAFE, link 2, ts 100. After yumi, pending_o returns to 0.
3. Same-cycle hits on links 0, 1, 3 with tags 'h10/'h11/'h13. FIFO order is 'h10, 'h11, 'h13. A later simultaneous 0 and 3 hit yields 'h10-class order per the pointer, i.e. link 0 first because the pointer sits at 0 after link 3.
4. FIFO full: fill 8 entries with no yumi, then 4 more hits on link 1. First extra hit is held in the capture register; the remaining 3 give drop_count_o=3. After one yumi the held entry enters the FIFO.
5. Drop saturation with drop_ctr_width_p=2: 5 drops give drop_count_o=3.
6. en_i=0: hits produce nothing. A store to stat_epa_p+4, or a load to stat_epa_p, with en_i=1 is also ignored.
